// File: rtl/mac_ram_unit.sv
// mac_ram_unit: 2-stage unsigned multiply-accumulate datapath sharing a clock
// with an independent dual-port read-first RAM. The two halves never talk to
// each other; an external controller moves operands and results between them.
module mac_ram_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_in_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_in_b,
    output logic [DATA_W-1:0] data_out_b,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              valid_in,
    output logic [ACC_W-1:0]  result,
    output logic              valid_out
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = 2 * DATA_W;

    // Accumulator add; wraps modulo 2^ACC_W with no saturation or flag.
    function automatic logic unsigned [ACC_W-1:0] acc_wrap_add(
        input logic unsigned [ACC_W-1:0]  acc,
        input logic unsigned [PROD_W-1:0] prod
    );
        return acc + ACC_W'(prod);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] rd_a_d, rd_a_q;
    logic [DATA_W-1:0] rd_b_d, rd_b_q;

    logic unsigned [PROD_W-1:0] prod_p1_d, prod_p1_q;
    logic                       vld_p1_d, vld_p1_q;
    logic unsigned [ACC_W-1:0]  acc_p2_d, acc_p2_q;
    logic                       vld_p2_d, vld_p2_q;

    // Storage array: port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we_a) mem_q[addr_a] <= data_in_a;
        if (we_b) mem_q[addr_b] <= data_in_b;
    end

    // Read every cycle; sampling the array before the write lands gives read-first.
    always_comb begin
        rd_a_d = mem_q[addr_a];
        rd_b_d = mem_q[addr_b];
    end

    // Registered read data; only these clear on reset, the array keeps its contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    // Next-state for both MAC stages.
    always_comb begin
        // stage p1: full-width unsigned product
        prod_p1_d = prod_p1_q;
        if (valid_in) prod_p1_d = PROD_W'(a) * PROD_W'(b);
        vld_p1_d  = valid_in;
        // stage p2: accumulate, hold when nothing arrives
        acc_p2_d  = acc_p2_q;
        if (vld_p1_q) acc_p2_d = acc_wrap_add(acc_p2_q, prod_p1_q);
        vld_p2_d  = vld_p1_q;
    end

    // MAC pipeline registers; async reset drops any in-flight product at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            acc_p2_q  <= '0;
            vld_p2_q  <= 1'b0;
        end else begin
            prod_p1_q <= prod_p1_d;
            vld_p1_q  <= vld_p1_d;
            acc_p2_q  <= acc_p2_d;
            vld_p2_q  <= vld_p2_d;
        end
    end

    assign data_out_a = rd_a_q;
    assign data_out_b = rd_b_q;
    assign result     = acc_p2_q;
    assign valid_out  = vld_p2_q;

endmodule

// File: tb/tb_mac_ram_unit.sv
// Testbench for mac_ram_unit: table-driven RAM/MAC vectors plus hand-written
// collision, wrap and reset sequences; MAC results checked via a scoreboard.
module tb_mac_ram_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [15:0] data_in_a, data_in_b;
    logic [15:0] data_out_a, data_out_b;
    logic [15:0] a, b;
    logic        valid_in;
    logic [31:0] result;
    logic        valid_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] val;
        int          due;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } rd_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } mac_vec_t;

    rd_vec_t  rd_tab[4];
    mac_vec_t mac_tab[4];

    mac_ram_unit #(.DATA_W(16), .ADDR_W(5), .ACC_W(32)) dut (
        .clk(clk), .reset(reset),
        .we_a(we_a), .addr_a(addr_a), .data_in_a(data_in_a), .data_out_a(data_out_a),
        .we_b(we_b), .addr_b(addr_b), .data_in_b(data_in_b), .data_out_b(data_out_b),
        .a(a), .b(b), .valid_in(valid_in), .result(result), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each expected pulse must appear exactly on its due cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks++;
            if (!valid_out) begin
                errors++;
                $display("FAIL vout_missing: cycle %0d valid_out=0 required 1 (exp result 0x%0h)", cyc, sb[0].val);
            end else if (result !== sb[0].val) begin
                errors++;
                $display("FAIL mac_result: cycle %0d got 0x%0h required 0x%0h", cyc, result, sb[0].val);
            end
            void'(sb.pop_front());
        end else if (valid_out) begin
            checks++;
            errors++;
            $display("FAIL vout_unexpected: cycle %0d valid_out=1 required 0", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic wea, input logic [4:0] aa, input logic [15:0] da,
                      input logic web, input logic [4:0] ab, input logic [15:0] db);
        we_a = wea; addr_a = aa; data_in_a = da;
        we_b = web; addr_b = ab; data_in_b = db;
        step();
        we_a = 1'b0; we_b = 1'b0;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rd_tab[0] = '{5'd0, 5'd8,  16'd4, 16'd3};
        rd_tab[1] = '{5'd1, 5'd9,  16'd5, 16'd3};
        rd_tab[2] = '{5'd2, 5'd10, 16'd6, 16'd2};
        rd_tab[3] = '{5'd3, 5'd11, 16'd7, 16'd1};
        mac_tab[0] = '{16'd4, 16'd3, 32'd12};
        mac_tab[1] = '{16'd5, 16'd3, 32'd27};
        mac_tab[2] = '{16'd6, 16'd2, 32'd39};
        mac_tab[3] = '{16'd7, 16'd1, 32'd46};

        reset = 1'b0;
        we_a = 0; we_b = 0; addr_a = 0; addr_b = 0; data_in_a = 0; data_in_b = 0;
        a = 0; b = 0; valid_in = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_dout_a", {16'd0, data_out_a}, 32'd0);
        chk("rst_dout_b", {16'd0, data_out_b}, 32'd0);
        reset = 1'b1;
        step();

        // Memory survives reset
        wr(1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0);
        addr_a = 5'd3;
        step();
        rst_pulse();
        chk("rst_clears_dout", {16'd0, data_out_a}, 32'd0);
        step();
        chk("mem_survives_reset", {16'd0, data_out_a}, 32'h1234);

        // Preload A at 0..3 (port A) and B at 8..11 (port B), then read back
        for (int i = 0; i < 4; i++)
            wr(1'b1, rd_tab[i].addr_a, rd_tab[i].exp_a, 1'b1, rd_tab[i].addr_b, rd_tab[i].exp_b);
        for (int i = 0; i < 4; i++) begin
            addr_a = rd_tab[i].addr_a;
            addr_b = rd_tab[i].addr_b;
            step();
            chk($sformatf("readback_a%0d", i), {16'd0, data_out_a}, {16'd0, rd_tab[i].exp_a});
            chk($sformatf("readback_b%0d", i), {16'd0, data_out_b}, {16'd0, rd_tab[i].exp_b});
        end

        // Single-pulse accumulation
        for (int i = 0; i < 4; i++) begin
            a = mac_tab[i].a; b = mac_tab[i].b; valid_in = 1'b1;
            sb.push_back('{mac_tab[i].exp, cyc + 2});
            step();
            valid_in = 1'b0;
            drain(3);
            chk($sformatf("acc_hold%0d", i), result, mac_tab[i].exp);
        end

        // Write results back at 16..19 and read them on port B
        for (int i = 0; i < 4; i++)
            wr(1'b1, 5'(16 + i), mac_tab[i].exp[15:0], 1'b0, 5'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            addr_b = 5'(16 + i);
            step();
            chk($sformatf("wb_read%0d", i), {16'd0, data_out_b}, mac_tab[i].exp);
        end

        // Streaming: four back-to-back operand pairs
        rst_pulse();
        chk("stream_rst", result, 32'd0);
        for (int i = 0; i < 4; i++) begin
            a = mac_tab[i].a; b = mac_tab[i].b; valid_in = 1'b1;
            sb.push_back('{mac_tab[i].exp, cyc + 2});
            step();
        end
        valid_in = 1'b0;
        drain(3);
        chk("stream_final", result, 32'd46);

        // Wrap modulo 2^32
        rst_pulse();
        for (int i = 0; i < 2; i++) begin
            a = 16'hFFFF; b = 16'hFFFF; valid_in = 1'b1;
            sb.push_back('{(i == 0) ? 32'hFFFE0001 : 32'hFFFC0002, cyc + 2});
            step();
        end
        valid_in = 1'b0;
        drain(3);
        chk("wrap_final", result, 32'hFFFC0002);

        // Reset mid-operation discards the in-flight product
        rst_pulse();
        a = 16'd9; b = 16'd9; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_result", result, 32'd0);
        step();
        reset = 1'b1;
        drain(3);
        chk("midrst_no_acc", result, 32'd0);

        // Collisions
        wr(1'b1, 5'd5, 16'h1111, 1'b1, 5'd5, 16'h2222);
        addr_b = 5'd5;
        wr(1'b1, 5'd5, 16'h3333, 1'b0, 5'd5, 16'h0);
        chk("rdw_same_port_old", {16'd0, data_out_a}, 32'h2222);
        chk("rdw_cross_port_old", {16'd0, data_out_b}, 32'h2222);
        step();
        chk("rdw_next_new", {16'd0, data_out_a}, 32'h3333);
        chk("rdw_next_new_b", {16'd0, data_out_b}, 32'h3333);

        drain(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d pending required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
